// File: rtl/opb_fifo_simulink2ppc_pkg.sv
// rtl/opb_fifo_simulink2ppc_pkg.sv - register offsets, status bit positions and bus FSM states
package opb_fifo_simulink2ppc_pkg;

  localparam logic [8:0] OFF_DATA   = 9'h000;
  localparam logic [8:0] OFF_STATUS = 9'h004;
  localparam logic [8:0] OFF_CTRL   = 9'h008;

  localparam int ST_BIT_EMPTY = 31;
  localparam int ST_BIT_FULL  = 30;
  localparam int ST_BIT_OVF   = 29;

  localparam int CTRL_BIT_FLUSH   = 0;
  localparam int CTRL_BIT_CLR_OVF = 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

endpackage

// File: rtl/opb_fifo_simulink2ppc_sync_fifo_ctrl.sv
// rtl/opb_fifo_simulink2ppc_sync_fifo_ctrl.sv - single-clock FIFO with push/pop/flush and overflow pulse
module sync_fifo_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign head     = mem[rd_ptr];
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && !flush && (!full || do_pop);
  assign overflow = push && !flush && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opb_fifo_simulink2ppc.sv
// rtl/opb_fifo_simulink2ppc.sv - OPB slave draining a user-fed FIFO to the PPC; OPB_FIFO_RETRY_EN retries empty reads
module opb_fifo_simulink2ppc
  import opb_fifo_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2400,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B24FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_DEPTH_LOG2 = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_we,
  output logic                    user_full
);

`ifdef OPB_FIFO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t                  state;
  logic [31:0]             abus_val;
  logic [31:0]             dbus_val;
  logic [8:0]              offset;
  logic                    in_window;
  logic [C_OPB_DWIDTH-1:0] head;
  logic [C_OPB_DWIDTH-1:0] status;
  logic [C_OPB_DWIDTH-1:0] rd_word;
  logic [C_OPB_DWIDTH-1:0] rd_q;
  logic                    empty;
  logic                    full;
  logic [C_DEPTH_LOG2:0]   count;
  logic                    ovf_pulse;
  logic                    ovf_sticky;
  logic                    ack_q;
  logic                    retry_q;
  logic                    pop_q;
  logic                    flush_q;
  logic                    clr_q;
  logic                    unused_ok;

  assign abus_val   = OPB_ABus;
  assign dbus_val   = OPB_DBus;
  assign offset     = abus_val[8:0];
  assign in_window  = (abus_val >= C_BASEADDR) && (abus_val <= C_HIGHADDR);
  assign unused_ok  = ^{OPB_BE, OPB_seqAddr, dbus_val[31:2]};

  assign Sl_DBus    = rd_q;
  assign Sl_xferAck = ack_q;
  assign Sl_retry   = retry_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_full  = full;

  sync_fifo_ctrl #(.WIDTH(C_OPB_DWIDTH), .DEPTH_LOG2(C_DEPTH_LOG2)) u_fifo (
    .clk       (OPB_Clk),
    .rst_n     (OPB_Rst_n),
    .push      (user_we),
    .push_data (user_data_in),
    .pop       (pop_q),
    .flush     (flush_q),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (ovf_pulse)
  );

  always_comb begin
    status                 = '0;
    status[ST_BIT_EMPTY]   = empty;
    status[ST_BIT_FULL]    = full;
    status[ST_BIT_OVF]     = ovf_sticky;
    status[C_DEPTH_LOG2:0] = count;
  end

  always_comb begin
    rd_word = '0;
    if (offset == OFF_DATA && !empty) rd_word = head;
    else if (offset == OFF_STATUS)    rd_word = status;
  end

  // Decode happens on the select edge; pop/flush/clear are committed in the ack cycle.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state   <= S_IDLE;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      retry_q <= 1'b0;
      pop_q   <= 1'b0;
      flush_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      rd_q    <= '0;
      ack_q   <= 1'b0;
      retry_q <= 1'b0;
      pop_q   <= 1'b0;
      flush_q <= 1'b0;
      clr_q   <= 1'b0;
      case (state)
        S_IDLE: if (OPB_select && in_window) begin
          state <= S_ACK;
          if (OPB_RNW && offset == OFF_DATA && empty && RETRY_EN) begin
            retry_q <= 1'b1;
          end else begin
            ack_q <= 1'b1;
            if (OPB_RNW) begin
              rd_q  <= rd_word;
              pop_q <= (offset == OFF_DATA) && !empty;
            end else if (offset == OFF_CTRL) begin
              flush_q <= dbus_val[CTRL_BIT_FLUSH];
              clr_q   <= dbus_val[CTRL_BIT_CLR_OVF];
            end
          end
        end
        S_ACK:   state <= S_WAIT;
        S_WAIT:  if (!OPB_select) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n)     ovf_sticky <= 1'b0;
    else if (ovf_pulse) ovf_sticky <= 1'b1;
    else if (clr_q)     ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_opb_fifo_simulink2ppc.sv
// tb/tb_opb_fifo_simulink2ppc.sv - randomized self-checking bench with a queue-based FIFO model
module tb_opb_fifo_simulink2ppc;

  localparam logic [31:0] BASE = 32'h010B2400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = 4'hF;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_in = '0;
  logic        user_we = 1'b0;
  logic        user_full;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  logic        m_ovf = 1'b0;

  opb_fifo_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(user_data_in), .user_we(user_we), .user_full(user_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(q.size());
    s[31] = (q.size() == 0);
    s[30] = (q.size() == 16);
    s[29] = m_ovf;
    return s;
  endfunction

  task automatic push(input logic [31:0] d);
    user_data_in = d;
    user_we = 1'b1;
    @(negedge clk);
    user_we = 1'b0;
    if (q.size() == 16) m_ovf = 1'b1;
    else q.push_back(d);
  endtask

  // Holds select for 'hold' cycles, then idles two cycles so the slave is back in IDLE.
  task automatic bus_xfer(input logic [31:0] a, input logic rnw, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output int nack,
                          output int nretry, output int lat);
    nack = 0; nretry = 0; rd = '0; lat = -1;
    OPB_ABus = a; OPB_RNW = rnw; OPB_DBus = wd; OPB_select = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (Sl_xferAck) begin nack++; rd = Sl_DBus; if (lat < 0) lat = i; end
      if (Sl_retry) nretry++;
    end
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_DBus = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_status(input string name);
    logic [31:0] rd; int na, nr, lat;
    bus_xfer(BASE + 4, 1'b1, 0, 2, rd, na, nr, lat);
    total++;
    if (rd !== model_status() || na != 1) begin
      bad++; $display("FAIL %s status got=%h acks=%0d exp=%h", name, rd, na, model_status());
    end
  endtask

  task automatic rd_data(input string name);
    logic [31:0] rd, exp; int na, nr, lat;
    bus_xfer(BASE, 1'b1, 0, 2, rd, na, nr, lat);
    exp = (q.size() == 0) ? 32'h0 : q.pop_front();
    total++;
    if (rd !== exp || na != 1 || lat != 0) begin
      bad++; $display("FAIL %s data got=%h acks=%0d lat=%0d exp=%h", name, rd, na, lat, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (Sl_xferAck !== 1'b0 || Sl_retry !== 1'b0 || Sl_DBus !== 32'h0 || user_full !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got ack=%b retry=%b dbus=%h full=%b exp 0 0 0 0",
                      Sl_xferAck, Sl_retry, Sl_DBus, user_full);
    end
    rd_status("reset");
  endtask

  task automatic test_basic();
    push(32'hDEADBEEF);
    push(32'h12345678);
    rd_data("basic_first");
    rd_data("basic_second");
    rd_status("basic_empty");
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 16; i++) begin
      push(32'(i));
      if (i == 15) begin
        total++;
        if (user_full !== 1'b1) begin bad++; $display("FAIL full_after_16 got=%b exp=1", user_full); end
      end
    end
    rd_status("overflow");
    for (int i = 0; i < 16; i++) rd_data("overflow_drain");
  endtask

  task automatic test_ctrl_clear();
    logic [31:0] rd; int na, nr, lat;
    for (int i = 0; i < 5; i++) push($urandom);
    rd_status("ctrl_before");
    bus_xfer(BASE + 8, 1'b0, 32'h3, 2, rd, na, nr, lat);
    q.delete(); m_ovf = 1'b0;
    total++;
    if (na != 1) begin bad++; $display("FAIL ctrl_write_ack got=%0d exp=1", na); end
    rd_status("ctrl_after");
  endtask

  task automatic test_hold();
    logic [31:0] rd, exp; int na, nr, lat;
    push($urandom); push($urandom);
    bus_xfer(BASE, 1'b1, 0, 6, rd, na, nr, lat);
    exp = q.pop_front();
    total++;
    if (na != 1 || rd !== exp) begin
      bad++; $display("FAIL hold_single_ack got acks=%0d data=%h exp acks=1 data=%h", na, rd, exp);
    end
    rd_status("hold_count");
    rd_data("hold_rest");
  endtask

  task automatic test_full_simul();
    logic [31:0] got, exp; int na;
    for (int i = 0; i < 16; i++) push($urandom);
    na = 0;
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(negedge clk);
    if (Sl_xferAck) na++;
    got = Sl_DBus;
    user_data_in = 32'hA5A5A5A5; user_we = 1'b1;
    @(negedge clk);
    user_we = 1'b0; OPB_select = 1'b0; OPB_RNW = 1'b0;
    repeat (2) @(negedge clk);
    exp = q.pop_front();
    q.push_back(32'hA5A5A5A5);
    total++;
    if (na != 1 || got !== exp) begin
      bad++; $display("FAIL full_simul_read got acks=%0d data=%h exp acks=1 data=%h", na, got, exp);
    end
    rd_status("full_simul");
    for (int i = 0; i < 16; i++) rd_data("full_simul_drain");
  endtask

  task automatic test_empty_read();
    logic [31:0] rd; int na, nr, lat;
    bus_xfer(BASE, 1'b1, 0, 3, rd, na, nr, lat);
    total++;
`ifdef OPB_FIFO_RETRY_EN
    if (na != 0 || nr != 1) begin
      bad++; $display("FAIL empty_read got acks=%0d retries=%0d exp acks=0 retries=1", na, nr);
    end
`else
    if (na != 1 || nr != 0 || rd !== 32'h0) begin
      bad++; $display("FAIL empty_read got acks=%0d retries=%0d data=%h exp 1 0 0", na, nr, rd);
    end
`endif
    rd_status("empty_read");
  endtask

  task automatic test_window();
    logic [31:0] rd; int na, nr, lat;
    bus_xfer(BASE + 32'h100, 1'b1, 0, 3, rd, na, nr, lat);
    total++;
    if (na != 0) begin bad++; $display("FAIL out_of_window got acks=%0d exp=0", na); end
    bus_xfer(BASE + 32'h10, 1'b1, 0, 2, rd, na, nr, lat);
    total++;
    if (na != 1 || rd !== 32'h0) begin
      bad++; $display("FAIL unmapped_read got acks=%0d data=%h exp 1 0", na, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, w; int na, nr, lat;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: push($urandom);
        4, 5: if (q.size() > 0) rd_data("rand_data"); else push($urandom);
        6: rd_status("rand_status");
        7: begin
          w = $urandom & 32'h3;
          if ($urandom_range(0, 3) != 0) w[0] = 1'b0;
          bus_xfer(BASE + 8, 1'b0, w, 2, rd, na, nr, lat);
          if (w[0]) q.delete();
          if (w[1]) m_ovf = 1'b0;
        end
        8: bus_xfer(BASE, 1'b0, $urandom, 2, rd, na, nr, lat);
        default: begin
          bus_xfer(BASE + 8, 1'b1, 0, 2, rd, na, nr, lat);
          total++;
          if (rd !== 32'h0 || na != 1) begin
            bad++; $display("FAIL ctrl_read got=%h acks=%0d exp 0 1", rd, na);
          end
        end
      endcase
    end
    rd_status("rand_final");
  endtask

  task automatic test_reset_mid();
    int na = 0;
    push($urandom);
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin @(negedge clk); if (Sl_xferAck) na++; end
    OPB_select = 1'b0; OPB_RNW = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0;
    @(negedge clk);
    total++;
    if (na != 0) begin bad++; $display("FAIL reset_mid_ack got=%0d exp=0", na); end
    rd_status("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ctrl_clear();
    test_hold();
    test_full_simul();
    test_empty_read();
    test_window();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
